// File: rtl/sprite_motion_ctrl_if.sv
// Control/status bundle between the frame timing logic and the sprite motion sequencer.
interface sprite_motion_ctrl_if;
    logic       FRAME_TICK;
    logic       ENABLE;
    logic [3:0] SPEED_X;
    logic [3:0] SPEED_Y;
    logic       LOAD;
    logic [9:0] LOAD_X;
    logic [8:0] LOAD_Y;
    logic       BLINK_EN;
    logic [5:0] BLINK_FRAMES;
    logic [9:0] SPRITE_ORIGIN_OFFSET_X;
    logic [8:0] SPRITE_ORIGIN_OFFSET_Y;
    logic       VISIBLE;
    logic       DIR_X;
    logic       DIR_Y;
    logic       BOUNCE;
    logic       BUSY;

    modport master (
        output FRAME_TICK, ENABLE, SPEED_X, SPEED_Y, LOAD, LOAD_X, LOAD_Y,
               BLINK_EN, BLINK_FRAMES,
        input  SPRITE_ORIGIN_OFFSET_X, SPRITE_ORIGIN_OFFSET_Y, VISIBLE,
               DIR_X, DIR_Y, BOUNCE, BUSY
    );

    modport slave (
        input  FRAME_TICK, ENABLE, SPEED_X, SPEED_Y, LOAD, LOAD_X, LOAD_Y,
               BLINK_EN, BLINK_FRAMES,
        output SPRITE_ORIGIN_OFFSET_X, SPRITE_ORIGIN_OFFSET_Y, VISIBLE,
               DIR_X, DIR_Y, BOUNCE, BUSY
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame origin sequencer for one sprite: bounces off screen edges and runs a
// frame-counted blink timer. All outputs are registered and move only after a frame tick.
module sprite_motion_ctrl #(
    parameter int SCREEN_WID = 640,
    parameter int SCREEN_HGT = 480,
    parameter int SPRITE_WID = 40,
    parameter int SPRITE_HGT = 40,
    parameter int INIT_X     = 0,
    parameter int INIT_Y     = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sprite_motion_ctrl_if.slave  bus
);

    localparam logic [9:0]  XMAX     = 10'(SCREEN_WID - SPRITE_WID);
    localparam logic [8:0]  YMAX     = 9'(SCREEN_HGT - SPRITE_HGT);
    localparam logic [10:0] XMAX_EXT = {1'b0, XMAX};
    localparam logic [9:0]  YMAX_EXT = {1'b0, YMAX};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_X = 2'd1,
        ST_MOVE_Y = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_x, w_x_nxt;
    logic [8:0]  r_y, w_y_nxt;
    logic        r_dir_x, w_dir_x_nxt;
    logic        r_dir_y, w_dir_y_nxt;
    logic        r_bounce, w_bounce_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_visible, w_visible_nxt;
    logic [5:0]  r_blink_cnt, w_blink_cnt_nxt;
    logic        w_tick_acc;
    logic [10:0] w_sum_x;
    logic [9:0]  w_sum_y;

    // Sums are one bit wider than the position so the edge compare never wraps.
    assign w_sum_x = {1'b0, r_x} + {7'b0, bus.SPEED_X};
    assign w_sum_y = {1'b0, r_y} + {6'b0, bus.SPEED_Y};

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, motion and bounce decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_dir_x_nxt  = r_dir_x;
        w_dir_y_nxt  = r_dir_y;
        w_bounce_nxt = 1'b0;
        w_tick_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.LOAD) begin
                    w_x_nxt = (bus.LOAD_X > XMAX) ? XMAX : bus.LOAD_X;
                    w_y_nxt = (bus.LOAD_Y > YMAX) ? YMAX : bus.LOAD_Y;
                end else if (bus.FRAME_TICK) begin
                    w_tick_acc  = 1'b1;
                    w_state_nxt = bus.ENABLE ? ST_MOVE_X : ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE_X: begin
                w_state_nxt = ST_MOVE_Y;
                if (bus.SPEED_X == 4'd0) begin
                    w_x_nxt = r_x;
                end else if (!r_dir_x) begin
                    if (w_sum_x >= XMAX_EXT) begin
                        w_x_nxt      = XMAX;
                        w_dir_x_nxt  = 1'b1;
                        w_bounce_nxt = 1'b1;
                    end else begin
                        w_x_nxt = w_sum_x[9:0];
                    end
                end else begin
                    if (r_x <= {6'b0, bus.SPEED_X}) begin
                        w_x_nxt      = 10'd0;
                        w_dir_x_nxt  = 1'b0;
                        w_bounce_nxt = 1'b1;
                    end else begin
                        w_x_nxt = r_x - {6'b0, bus.SPEED_X};
                    end
                end
            end
            ST_MOVE_Y: begin
                w_state_nxt = ST_IDLE;
                if (bus.SPEED_Y == 4'd0) begin
                    w_y_nxt = r_y;
                end else if (!r_dir_y) begin
                    if (w_sum_y >= YMAX_EXT) begin
                        w_y_nxt      = YMAX;
                        w_dir_y_nxt  = 1'b1;
                        w_bounce_nxt = 1'b1;
                    end else begin
                        w_y_nxt = w_sum_y[8:0];
                    end
                end else begin
                    if (r_y <= {5'b0, bus.SPEED_Y}) begin
                        w_y_nxt      = 9'd0;
                        w_dir_y_nxt  = 1'b0;
                        w_bounce_nxt = 1'b1;
                    end else begin
                        w_y_nxt = r_y - {5'b0, bus.SPEED_Y};
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Blink timer: only ticks accepted in IDLE advance it; disabling forces visible.
    always_comb begin
        w_visible_nxt   = r_visible;
        w_blink_cnt_nxt = r_blink_cnt;
        if (!bus.BLINK_EN) begin
            w_visible_nxt   = 1'b1;
            w_blink_cnt_nxt = 6'd0;
        end else if (w_tick_acc) begin
            if (r_blink_cnt == bus.BLINK_FRAMES) begin
                w_visible_nxt   = ~r_visible;
                w_blink_cnt_nxt = 6'd0;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 6'd1;
            end
        end else begin
            w_blink_cnt_nxt = r_blink_cnt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x         <= 10'(INIT_X);
            r_y         <= 9'(INIT_Y);
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_bounce    <= 1'b0;
            r_busy      <= 1'b0;
            r_visible   <= 1'b1;
            r_blink_cnt <= 6'd0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_bounce    <= w_bounce_nxt;
            r_busy      <= w_busy_nxt;
            r_visible   <= w_visible_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
        end
    end

    assign bus.SPRITE_ORIGIN_OFFSET_X = r_x;
    assign bus.SPRITE_ORIGIN_OFFSET_Y = r_y;
    assign bus.VISIBLE                = r_visible;
    assign bus.DIR_X                  = r_dir_x;
    assign bus.DIR_Y                  = r_dir_y;
    assign bus.BOUNCE                 = r_bounce;
    assign bus.BUSY                   = r_busy;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: hand-computed positions, bounces, blink and abort cases.
module tb_sprite_motion_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sprite_motion_ctrl_if bus ();

    sprite_motion_ctrl dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        assert (obs === 32'(exp)) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_xy(input string tag, input int ex, input int ey);
        chk({tag, "_x"}, 32'(bus.SPRITE_ORIGIN_OFFSET_X), ex);
        chk({tag, "_y"}, 32'(bus.SPRITE_ORIGIN_OFFSET_Y), ey);
    endtask

    task automatic do_load(input int lx, input int ly);
        bus.LOAD   = 1'b1;
        bus.LOAD_X = 10'(lx);
        bus.LOAD_Y = 9'(ly);
        clk1;
        bus.LOAD   = 1'b0;
    endtask

    // Pulses one tick and stops at t+3 (after Y update).
    task automatic do_tick3;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
        clk1;
        clk1;
    endtask

    task automatic tick1;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.FRAME_TICK   = 1'b0;
        bus.ENABLE       = 1'b0;
        bus.SPEED_X      = 4'd0;
        bus.SPEED_Y      = 4'd0;
        bus.LOAD         = 1'b0;
        bus.LOAD_X       = 10'd0;
        bus.LOAD_Y       = 9'd0;
        bus.BLINK_EN     = 1'b0;
        bus.BLINK_FRAMES = 6'd0;
        clk1;
        clk1;
        rst = 1'b0;
        chk_xy("rst", 0, 0);
        chk("rst_vis", 32'(bus.VISIBLE), 1);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_dirx", 32'(bus.DIR_X), 0);
        chk("rst_diry", 32'(bus.DIR_Y), 0);
        chk("rst_bounce", 32'(bus.BOUNCE), 0);

        // First tick: X at t+2, Y at t+3, BUSY for exactly two cycles.
        bus.ENABLE  = 1'b1;
        bus.SPEED_X = 4'd3;
        bus.SPEED_Y = 4'd2;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
        chk("t1_busy", 32'(bus.BUSY), 1);
        chk_xy("t1", 0, 0);
        clk1;
        chk("t2_busy", 32'(bus.BUSY), 1);
        chk_xy("t2", 3, 0);
        clk1;
        chk("t3_busy", 32'(bus.BUSY), 0);
        chk_xy("t3", 3, 2);
        chk("t3_bounce", 32'(bus.BOUNCE), 0);

        // Right-edge bounce.
        do_load(598, 100);
        chk_xy("ld598", 598, 100);
        bus.SPEED_X = 4'd5;
        bus.SPEED_Y = 4'd0;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
        chk("rb_t1_bounce", 32'(bus.BOUNCE), 0);
        clk1;
        chk_xy("rb_t2", 600, 100);
        chk("rb_dirx", 32'(bus.DIR_X), 1);
        chk("rb_t2_bounce", 32'(bus.BOUNCE), 1);
        clk1;
        chk("rb_t3_bounce", 32'(bus.BOUNCE), 0);
        do_tick3;
        chk_xy("rb_next", 595, 100);
        chk("rb_next_dirx", 32'(bus.DIR_X), 1);

        // Bottom-edge bounce to get DIR_Y=1; X holds with zero speed even though moving left.
        do_load(595, 438);
        bus.SPEED_X = 4'd0;
        bus.SPEED_Y = 4'd4;
        do_tick3;
        chk_xy("bb", 595, 440);
        chk("bb_diry", 32'(bus.DIR_Y), 1);
        chk("bb_bounce", 32'(bus.BOUNCE), 1);

        // Corner: two separate bounce pulses.
        do_load(2, 1);
        bus.SPEED_X = 4'd4;
        bus.SPEED_Y = 4'd4;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
        chk("cn_t1_bounce", 32'(bus.BOUNCE), 0);
        clk1;
        chk_xy("cn_t2", 0, 1);
        chk("cn_t2_bounce", 32'(bus.BOUNCE), 1);
        chk("cn_dirx", 32'(bus.DIR_X), 0);
        clk1;
        chk_xy("cn_t3", 0, 0);
        chk("cn_t3_bounce", 32'(bus.BOUNCE), 1);
        chk("cn_diry", 32'(bus.DIR_Y), 0);
        clk1;
        chk("cn_t4_bounce", 32'(bus.BOUNCE), 0);
        chk("cn_t4_busy", 32'(bus.BUSY), 0);

        // Blink with half-period 3; LOAD+tick collision in the middle must not step the counter.
        bus.ENABLE       = 1'b0;
        bus.BLINK_EN     = 1'b1;
        bus.BLINK_FRAMES = 6'd2;
        clk1;
        tick1;
        chk("bl_1", 32'(bus.VISIBLE), 1);
        tick1;
        chk("bl_2", 32'(bus.VISIBLE), 1);
        bus.ENABLE     = 1'b1;
        bus.LOAD       = 1'b1;
        bus.LOAD_X     = 10'd700;
        bus.LOAD_Y     = 9'd500;
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.LOAD       = 1'b0;
        bus.FRAME_TICK = 1'b0;
        chk_xy("clamp", 600, 440);
        chk("clamp_busy", 32'(bus.BUSY), 0);
        chk("clamp_vis", 32'(bus.VISIBLE), 1);
        clk1;
        chk("clamp_busy2", 32'(bus.BUSY), 0);
        chk_xy("clamp_hold", 600, 440);
        bus.ENABLE = 1'b0;
        tick1;
        chk("bl_3", 32'(bus.VISIBLE), 0);
        tick1;
        chk("bl_4", 32'(bus.VISIBLE), 0);
        tick1;
        chk("bl_5", 32'(bus.VISIBLE), 0);
        tick1;
        chk("bl_6", 32'(bus.VISIBLE), 1);
        chk_xy("bl_hold", 600, 440);
        bus.BLINK_FRAMES = 6'd0;
        tick1;
        chk("bl0_a", 32'(bus.VISIBLE), 0);
        tick1;
        chk("bl0_b", 32'(bus.VISIBLE), 1);
        tick1;
        chk("bl0_c", 32'(bus.VISIBLE), 0);
        bus.BLINK_EN = 1'b0;
        clk1;
        chk("bl_off", 32'(bus.VISIBLE), 1);

        // Tick and LOAD while busy are ignored.
        do_load(100, 100);
        bus.ENABLE  = 1'b1;
        bus.SPEED_X = 4'd4;
        bus.SPEED_Y = 4'd4;
        bus.FRAME_TICK = 1'b1;
        clk1;
        chk("bz_t1_busy", 32'(bus.BUSY), 1);
        bus.LOAD   = 1'b1;
        bus.LOAD_X = 10'd7;
        bus.LOAD_Y = 9'd7;
        clk1;
        bus.FRAME_TICK = 1'b0;
        bus.LOAD       = 1'b0;
        chk_xy("bz_t2", 104, 100);
        clk1;
        chk_xy("bz_t3", 104, 104);
        chk("bz_t3_busy", 32'(bus.BUSY), 0);
        clk1;
        chk("bz_t4_busy", 32'(bus.BUSY), 0);
        chk_xy("bz_t4", 104, 104);

        // Reset in MOVE_X aborts the update.
        bus.FRAME_TICK = 1'b1;
        clk1;
        bus.FRAME_TICK = 1'b0;
        chk("ab_busy", 32'(bus.BUSY), 1);
        rst = 1'b1;
        clk1;
        rst = 1'b0;
        chk_xy("ab", 0, 0);
        chk("ab_busy2", 32'(bus.BUSY), 0);
        clk1;
        chk_xy("ab_hold", 0, 0);
        chk("ab_busy3", 32'(bus.BUSY), 0);
        chk("ab_bounce", 32'(bus.BOUNCE), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Per-frame position and visibility sequencer for one 40x40 sprite.
- Once per FRAME_TICK (start of vertical blank), advances the sprite origin by a programmable velocity and bounces it off the screen edges.
- Also runs a frame-counted blink timer.
- Outputs drive the sprite renderer's origin-offset and VISIBLE inputs directly. They change only during blanking, so each frame renders from one stable origin.

Parameters:
- SCREEN_WID, 640, active pixels per line.
- SCREEN_HGT, 480, active lines.
- SPRITE_WID, 40, sprite width in pixels.
- SPRITE_HGT, 40, sprite height in lines.
- INIT_X, 0, origin X after reset.
- INIT_Y, 0, origin Y after reset.

Ports:
- CLK  input  1  system clock; single clock domain.
- RESET  input  1  synchronous, active-high reset.
- FRAME_TICK  input  1  one-cycle pulse per frame, asserted during blanking.
- ENABLE  input  1  motion enable; 0 holds the position.
- SPEED_X  input  4  pixels moved per frame in X (magnitude).
- SPEED_Y  input  4  lines moved per frame in Y (magnitude).
- LOAD  input  1  one-cycle request to set the position directly.
- LOAD_X  input  10  X value used with LOAD.
- LOAD_Y  input  9  Y value used with LOAD.
- BLINK_EN  input  1  enables blinking.
- BLINK_FRAMES  input  6  blink half-period is BLINK_FRAMES+1 frames.
- SPRITE_ORIGIN_OFFSET_X  output  10  sprite origin X (registered).
- SPRITE_ORIGIN_OFFSET_Y  output  9  sprite origin Y (registered).
- VISIBLE  output  1  sprite visibility (registered).
- DIR_X  output  1  0 = moving right, 1 = moving left.
- DIR_Y  output  1  0 = moving down, 1 = moving up.
- BOUNCE  output  1  one-cycle pulse when any axis reverses.
- BUSY  output  1  high while an update is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - X = INIT_X, Y = INIT_Y.
  - DIR_X = DIR_Y = 0.
  - VISIBLE = 1, BOUNCE = 0, BUSY = 0.
  - blink counter = 0, FSM = IDLE.
  - RESET during MOVE_X or MOVE_Y aborts the update; no partial result is kept.
- Limits:
  - XMAX = SCREEN_WID - SPRITE_WID (600 by default).
  - YMAX = SCREEN_HGT - SPRITE_HGT (440 by default).
  - All sums are computed 1 bit wider than the position, so no wrap-around.
- FSM states: IDLE -> MOVE_X -> MOVE_Y -> IDLE.
  - BUSY = 1 in MOVE_X and MOVE_Y.
- IDLE, priority order:
  1. LOAD=1: X = min(LOAD_X, XMAX) and Y = min(LOAD_Y, YMAX) at the next edge. DIR_X and DIR_Y are unchanged. A simultaneous FRAME_TICK is dropped entirely, including its blink step.
  2. Else FRAME_TICK=1: step the blink logic. If ENABLE=1, go to MOVE_X. If ENABLE=0, stay in IDLE.
- MOVE_X (one cycle; X is updated at the end of this cycle):
  - Moving right: if X+SPEED_X >= XMAX, then X = XMAX and DIR_X = 1. Otherwise X = X+SPEED_X.
  - Moving left: if X <= SPEED_X, then X = 0 and DIR_X = 0. Otherwise X = X-SPEED_X.
  - SPEED_X = 0: X and DIR_X hold, and no bounce occurs, even at an edge.
- MOVE_Y (one cycle): same rules as MOVE_X using Y, YMAX, SPEED_Y and DIR_Y.
- Timing, with FRAME_TICK high at cycle t:
  - new X is visible at t+2.
  - new Y is visible at t+3.
  - BUSY is high in cycles t+1 and t+2.
- BOUNCE:
  - Registered; high for exactly one cycle after each reversal.
  - Fires at t+2 for an X bounce and at t+3 for a Y bounce. A corner hit gives two separate pulses.
- Inputs while BUSY:
  - FRAME_TICK and LOAD are ignored.
  - SPEED_X and SPEED_Y are sampled during the MOVE state that uses them.
- Blink:
  - BLINK_EN = 0: VISIBLE = 1 and the counter is cleared, both at the next edge.
  - BLINK_EN = 1, on each accepted tick: if counter == BLINK_FRAMES, toggle VISIBLE and clear the counter. Otherwise increment the counter.
  - BLINK_FRAMES = 0 therefore toggles VISIBLE on every tick.
- Outputs change only at the edges described above; otherwise they hold.

Test Plan:
- Reset and first tick: RESET for 2 cycles, then FRAME_TICK with ENABLE=1, SPEED_X=3, SPEED_Y=2 -> X=0, Y=0, VISIBLE=1 after reset; X=3 at t+2, Y=2 at t+3; BUSY high for exactly 2 cycles.
- Right-edge bounce: LOAD_X=598, then a tick with SPEED_X=5 -> X=600, DIR_X=1, BOUNCE pulse at t+2; next tick -> X=595.
- Top-edge and corner bounce: LOAD_X=2, LOAD_Y=1, DIR_X=DIR_Y=1 (set up by earlier bounces), SPEED_X=SPEED_Y=4, then a tick -> X=0 with a BOUNCE pulse at t+2, Y=0 with a BOUNCE pulse at t+3; DIR_X=DIR_Y=0.
- LOAD clamp and collision: LOAD with LOAD_X=700, LOAD_Y=500 in the same cycle as FRAME_TICK -> X=600, Y=440; no MOVE states, BUSY stays 0, blink counter unchanged.
- Blink: BLINK_EN=1, BLINK_FRAMES=2, then 6 ticks -> VISIBLE toggles after tick 3 and again after tick 6; deassert BLINK_EN -> VISIBLE=1 next cycle.
- Busy/abort: FRAME_TICK re-pulsed and LOAD asserted at t+1 -> both ignored; in a separate run, RESET asserted at t+1 -> X=INIT_X, Y=INIT_Y, FSM in IDLE.
